// File: rtl/main_control_sequencer_if.sv
// ============================================================================
// Module  : main_control_sequencer_if
// Brief   : Control bus between the main control sequencer and the datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface main_control_sequencer_if #(
    parameter int RETIRE_W = 16
);
    logic [3:0]          OPcode;
    logic                mem_ack;
    logic                resume;
    logic [8:0]          CONTROL_PIPE;
    logic [1:0]          ALU_OPcode;
    logic                pc_en;
    logic                halted;
    logic                bus_err;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  OPcode, mem_ack, resume,
        output CONTROL_PIPE, ALU_OPcode, pc_en, halted, bus_err, retired
    );

    modport slave (
        output OPcode, mem_ack, resume,
        input  CONTROL_PIPE, ALU_OPcode, pc_en, halted, bus_err, retired
    );
endinterface

`default_nettype wire

// File: rtl/main_control_sequencer.sv
// ============================================================================
// Module  : main_control_sequencer
// Brief   : Opcode decode plus boot/memory-wait/halt/trap sequencing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module main_control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    main_control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_HALT     = 3'd3,
        ST_TRAP     = 3'd4
    } state_t;

    localparam logic [7:0] c_TIMEOUT   = 8'(MEM_TIMEOUT);
    // Strips write_enable (bit7) and mem_to_reg (bit6) while memory is pending
    localparam logic [8:0] c_WAIT_MASK = 9'h13F;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_wait_cnt;
    logic [7:0]          w_wait_cnt_next;
    logic [RETIRE_W-1:0] r_retired;

    logic [8:0] w_dec_ctrl;
    logic [1:0] w_dec_alu;
    logic       w_is_mem;
    logic       w_is_halt;

    logic [8:0] w_ctrl;
    logic [1:0] w_alu;
    logic       w_pc_en;
    logic       w_retire;

    always_comb begin
        w_dec_ctrl = 9'h000;
        w_dec_alu  = 2'b00;
        w_is_mem   = 1'b0;
        w_is_halt  = 1'b0;
        case (bus.OPcode)
            4'b0000: begin w_dec_ctrl = 9'h0D4; w_dec_alu = 2'b10; w_is_mem = 1'b1; end
            4'b0001: begin w_dec_ctrl = 9'h018; w_dec_alu = 2'b10; w_is_mem = 1'b1; end
            4'b1010: begin w_dec_ctrl = 9'h090; w_dec_alu = 2'b10; end
            4'b1011: begin w_dec_ctrl = 9'h002; w_dec_alu = 2'b01; end
            4'b1100: begin w_dec_ctrl = 9'h100; w_dec_alu = 2'b01; end
            4'b1101: begin w_dec_ctrl = 9'h001; w_dec_alu = 2'b00; end
            4'b1110: begin w_dec_ctrl = 9'h000; w_dec_alu = 2'b00; end
            4'b1111: begin w_is_halt = 1'b1; end
            default: begin w_dec_ctrl = 9'h0A0; w_dec_alu = 2'b00; end
        endcase
    end

    always_comb begin
        w_next          = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_ctrl          = 9'h000;
        w_alu           = 2'b00;
        w_pc_en         = 1'b0;
        w_retire        = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_is_halt) begin
                    w_next   = ST_HALT;
                    w_retire = 1'b1;
                end else if (w_is_mem && !bus.mem_ack) begin
                    w_ctrl          = w_dec_ctrl & c_WAIT_MASK;
                    w_alu           = w_dec_alu;
                    w_wait_cnt_next = 8'd1;
                    w_next          = ST_MEM_WAIT;
                end else begin
                    w_ctrl   = w_dec_ctrl;
                    w_alu    = w_dec_alu;
                    w_pc_en  = 1'b1;
                    w_retire = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                w_alu = w_dec_alu;
                // Acknowledge wins over timeout when both land on the same cycle
                if (bus.mem_ack) begin
                    w_ctrl          = w_dec_ctrl;
                    w_pc_en         = 1'b1;
                    w_retire        = 1'b1;
                    w_wait_cnt_next = 8'd0;
                    w_next          = ST_RUN;
                end else begin
                    w_ctrl = w_dec_ctrl & c_WAIT_MASK;
                    if (r_wait_cnt == c_TIMEOUT) begin
                        w_next = ST_TRAP;
                    end else begin
                        w_wait_cnt_next = r_wait_cnt + 8'd1;
                    end
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    w_next = ST_RUN;
                end
            end
            ST_TRAP: begin
                w_next = ST_TRAP;
            end
            default: begin
                w_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_wait_cnt <= 8'd0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign bus.CONTROL_PIPE = w_ctrl;
    assign bus.ALU_OPcode   = w_alu;
    assign bus.pc_en        = w_pc_en;
    assign bus.halted       = (r_state == ST_HALT);
    assign bus.bus_err      = (r_state == ST_TRAP);
    assign bus.retired      = r_retired;

endmodule

`default_nettype wire
